// File: rtl/wb_regfile_if.sv
// Bus bundle between the M/W pipeline register, the decode read ports and
// the writeback register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegW_enable_W;
  logic              Result_src_W;
  logic [DATA_W-1:0] ALU_result_W;
  logic [DATA_W-1:0] mem_read_W;
  logic [ADDR_W-1:0] RDadd_W;
  logic [ADDR_W-1:0] RS1add_D;
  logic [ADDR_W-1:0] RS2add_D;
  logic [DATA_W-1:0] RD1_D;
  logic [DATA_W-1:0] RD2_D;
  logic [DATA_W-1:0] Result_W;
  logic [31:0]       wb_count;

  modport master (
    output RegW_enable_W, Result_src_W, ALU_result_W, mem_read_W,
           RDadd_W, RS1add_D, RS2add_D,
    input  RD1_D, RD2_D, Result_W, wb_count
  );

  modport slave (
    input  RegW_enable_W, Result_src_W, ALU_result_W, mem_read_W,
           RDadd_W, RS1add_D, RS2add_D,
    output RD1_D, RD2_D, Result_W, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: result select, integer register file commit with
// same-cycle read bypass, and a debug commit counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int NREGS = int'(32'd1 << ADDR_W);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [31:0]       wb_count_r;
  logic [DATA_W-1:0] result_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              commit_s;

  // x0 reads as zero; a read of the register being committed this cycle sees the new value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              commit,
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (addr == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if (commit && (addr == rd_addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Commit is blocked during reset so reads in a reset cycle return storage only.
  assign commit_s = bus.RegW_enable_W && (bus.RDadd_W != {ADDR_W{1'b0}}) && !rst;

  // Writeback result select.
  always_comb begin
    result_s = bus.ALU_result_W;
    if (bus.Result_src_W) begin
      result_s = bus.mem_read_W;
    end else begin
      result_s = bus.ALU_result_W;
    end
  end

  // Decode-stage read ports with write bypass.
  always_comb begin
    rd1_s = read_port(bus.RS1add_D, commit_s, bus.RDadd_W, result_s, regs_r[bus.RS1add_D]);
    rd2_s = read_port(bus.RS2add_D, commit_s, bus.RDadd_W, result_s, regs_r[bus.RS2add_D]);
  end

  // Register storage and commit counter; reset wins over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      wb_count_r <= 32'd0;
    end else if (commit_s) begin
      regs_r[bus.RDadd_W] <= result_s;
      wb_count_r          <= wb_count_r + 32'd1;
    end else begin
      wb_count_r <= wb_count_r;
    end
  end

  assign bus.Result_W = result_s;
  assign bus.RD1_D    = rd1_s;
  assign bus.RD2_D    = rd2_s;
  assign bus.wb_count = wb_count_r;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset sweep, a table of write/read vectors,
// then hand sequences for reset-during-commit and counter wrap.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        src;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_res;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.RegW_enable_W = we;
    bus.Result_src_W  = src;
    bus.ALU_result_W  = alu;
    bus.mem_read_W    = mem;
    bus.RDadd_W       = rd;
    bus.RS1add_D      = rs1;
    bus.RS2add_D      = rs2;
  endtask

  // Advance to the next falling edge, where inputs change and outputs are sampled.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    // Fields: we, src, alu, mem, rd, rs1, rs2, exp rd1, exp rd2, exp result, exp count
    vecs[0]  = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 5'd5,  5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 32'd1};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7,  5'd7,  5'd5,  32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_0000, 5'd0,  5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'hAAAA_AAAA, 32'd2};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_3333, 32'h0000_0000, 5'd3,  5'd3,  5'd0,  32'h0000_3333, 32'h0000_0000, 32'h0000_3333, 32'd2};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0055, 32'h0000_0000, 5'd3,  5'd3,  5'd3,  32'h0000_3333, 32'h0000_3333, 32'h0000_0055, 32'd3};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0099, 5'd3,  5'd3,  5'd7,  32'h0000_3333, 32'h1234_5678, 32'h0000_0099, 32'd3};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 5'd12, 5'd12, 5'd12, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0BAD_C0DE, 32'h0000_0000, 5'd12, 5'd12, 5'd5,  32'h0BAD_C0DE, 32'hDEAD_BEEF, 32'h0BAD_C0DE, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000, 5'd12, 5'd12, 5'd3,  32'h0BAD_C0DE, 32'h0000_3333, 32'h0000_0001, 32'd5};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 5'd31, 5'd31, 5'd1,  32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000, 32'd5};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  5'd31, 5'd31, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000, 32'd6};

    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset sweep over every address on both ports.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(a), 5'(31 - a));
      #1;
      check($sformatf("reset_rd1[%0d]", a), bus.RD1_D, 32'h0);
      check($sformatf("reset_rd2[%0d]", a), bus.RD2_D, 32'h0);
    end
    check("reset_count", bus.wb_count, 32'd0);
    next_cycle();

    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].we, vecs[v].src, vecs[v].alu, vecs[v].mem,
            vecs[v].rd, vecs[v].rs1, vecs[v].rs2);
      #1;
      check($sformatf("vec%0d_rd1", v), bus.RD1_D, vecs[v].e_rd1);
      check($sformatf("vec%0d_rd2", v), bus.RD2_D, vecs[v].e_rd2);
      check($sformatf("vec%0d_result", v), bus.Result_W, vecs[v].e_res);
      check($sformatf("vec%0d_count", v), bus.wb_count, vecs[v].e_cnt);
      next_cycle();
    end

    // Reset colliding with a commit: storage seen in that cycle, then cleared.
    drive(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd9, 5'd9, 5'd9);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd9, 5'd9, 5'd9);
    #1;
    check("rstcycle_rd1", bus.RD1_D, 32'h0000_0011);
    check("rstcycle_rd2", bus.RD2_D, 32'h0000_0011);
    check("rstcycle_result", bus.Result_W, 32'h0000_0077);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);
    #1;
    check("postrst_x9", bus.RD1_D, 32'h0);
    check("postrst_x5", bus.RD2_D, 32'h0);
    check("postrst_count", bus.wb_count, 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_0022, 32'h0, 5'd9, 5'd9, 5'd0);
    #1;
    check("first_commit_bypass", bus.RD1_D, 32'h0000_0022);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    #1;
    check("first_commit_stored", bus.RD2_D, 32'h0000_0022);
    check("first_commit_count", bus.wb_count, 32'd1);
    next_cycle();

    // Counter wrap from the all-ones state.
    force dut.wb_count_r = 32'hFFFF_FFFF;
    #1;
    check("preload_count", bus.wb_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h0000_0005, 32'h0, 5'd4, 5'd4, 5'd0);
    release dut.wb_count_r;
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    #1;
    check("wrap_count", bus.wb_count, 32'd0);
    check("wrap_x4", bus.RD1_D, 32'h0000_0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer for the M/W pipeline register outputs. Selects the writeback result (ALU or memory), commits it to a 32 x 32-bit integer register file, and serves the decode stage's two read ports with same-cycle write bypass. Also exports the selected result for execute-stage forwarding and keeps a commit counter for debug.

## Interface
- DATA_W, 32, register and result width
- ADDR_W, 5, register address width (2^ADDR_W registers, x0 included)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- RegW_enable_W  in  1  write enable from M/W register
- Result_src_W  in  1  result select: 0 = ALU_result_W, 1 = mem_read_W
- ALU_result_W  in  DATA_W  ALU result from M/W register
- mem_read_W  in  DATA_W  load data from M/W register
- RDadd_W  in  ADDR_W  destination register address
- RS1add_D  in  ADDR_W  decode read address, port 1
- RS2add_D  in  ADDR_W  decode read address, port 2
- RD1_D  out  DATA_W  read data, port 1 (combinational)
- RD2_D  out  DATA_W  read data, port 2 (combinational)
- Result_W  out  DATA_W  selected writeback value (combinational), to forwarding mux
- wb_count  out  32  number of committed register writes since reset

## Operation
- Result_W = Result_src_W ? mem_read_W : ALU_result_W; always driven, independent of enable.
- Commit condition: RegW_enable_W == 1 and RDadd_W != 0 and rst == 0. On commit, regs[RDadd_W] <= Result_W at the rising edge.
- x0: never stored; reads of address 0 return 0 regardless of any write to 0.
- Read port n (n = 1, 2): if address == 0 -> 0; else if commit condition true this cycle and address == RDadd_W -> Result_W (bypass); else regs[address].
- Both read ports independent; both may hit the same register, both may bypass simultaneously.
- wb_count increments by 1 on each commit; writes to x0 and disabled cycles do not count; wraps 0xFFFF_FFFF -> 0.
- Reset: all registers 1..31 cleared to 0, wb_count cleared to 0. Reset has priority over a commit in the same cycle; during rst, bypass is suppressed (commit condition false), so reads return stored values.
- No X propagation: all storage defined after first reset cycle.

## Timing
- Write latency: value committed at edge N is returned from storage from cycle N+1 onward; in cycle N itself it is returned via bypass.
- Read latency: 0 cycles (combinational from RS*add_D, RDadd_W, RegW_enable_W, Result_src_W, data inputs).
- Result_W: 0-cycle combinational.
- wb_count reflects commit at edge N from cycle N+1.
- Reset values after one rst cycle: RD1_D/RD2_D = 0 for any address, wb_count = 0, Result_W follows inputs (not reset).
- Reset asserted mid-stream: pending commit in the rst cycle is dropped; first commit after rst deasserts lands normally.

## Test plan
- Reset then read all 32 addresses on both ports -> every read 0, wb_count = 0.
- Write x5 = 0xDEADBEEF (Result_src_W=0), next cycle read RS1=5, RS2=5 -> both 0xDEADBEEF; wb_count = 1.
- Load writeback: Result_src_W=1, mem_read_W=0x1234_5678, ALU_result_W=0xFFFF_FFFF, RDadd_W=7 -> Result_W = 0x1234_5678 same cycle, RD1_D(RS1=7) = 0x1234_5678 via bypass same cycle, stored afterwards.
- Write x0 = 0xAAAA_AAAA with enable -> reads of x0 = 0, including same-cycle bypass; wb_count unchanged.
- RegW_enable_W=0 with RDadd_W=3, data 0x55 -> x3 keeps prior value, no bypass, wb_count unchanged.
- Assert rst in same cycle as commit x9 = 0x77 after x9 held 0x11 -> x9 = 0 after reset, same-cycle read of x9 returns 0x11 (stored, no bypass); preload wb_count to 0xFFFF_FFFF via forced state and commit once -> wraps to 0.
